// File: rtl/board_disp_pkg.sv
// Shared definitions for the tic-tac-toe display stage: cell and winner
// codes, active-low seven-segment glyphs ({g,f,e,d,c,b,a}) and the FSM state.
package board_disp_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'd0;
    localparam logic [1:0] CELL_O     = 2'd1;
    localparam logic [1:0] CELL_X     = 2'd2;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;

    localparam logic [6:0] GLYPH_EMPTY = 7'b0111111;
    localparam logic [6:0] GLYPH_O     = 7'b1000000;
    localparam logic [6:0] GLYPH_X     = 7'b0001001;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;
    localparam logic [6:0] GLYPH_P     = 7'b0001100;
    localparam logic [6:0] GLYPH_D     = 7'b0100001;
    localparam logic [6:0] GLYPH_R     = 7'b0101111;
    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;

    typedef enum logic [2:0] {
        PLAY,
        SCAN0,
        SCAN1,
        SCAN2,
        RESULT
    } disp_state_t;

    // Digit glyph for a row index or player number (0..2); anything else blank.
    function automatic logic [6:0] digit_glyph(input logic [1:0] d);
        case (d)
            2'd0:    digit_glyph = GLYPH_0;
            2'd1:    digit_glyph = GLYPH_1;
            2'd2:    digit_glyph = GLYPH_2;
            default: digit_glyph = GLYPH_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/cell_glyph.sv
// Maps one 2-bit board cell code to its active-low segment pattern.
// The blank flag overrides the cell (used for the hidden cursor phase).
module cell_glyph
    import board_disp_pkg::*;
(
    input  logic [1:0] code,
    input  logic       blank,
    output logic [6:0] seg
);

    // Pure lookup; invalid code 3 renders blank.
    always_comb begin
        seg = GLYPH_BLANK;
        if (!blank) begin
            case (code)
                CELL_EMPTY: seg = GLYPH_EMPTY;
                CELL_O:     seg = GLYPH_O;
                CELL_X:     seg = GLYPH_X;
                default:    seg = GLYPH_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/board_hex_display.sv
// Display stage for the tic-tac-toe board: shows the cursor row during play,
// and cycles rows 0..2 plus a result banner at game end.
// Optional macro BOARD_DISP_BLINK_EN: blink the cursor cell during play.
module board_hex_display
    import board_disp_pkg::*;
#(
    parameter int BLINK_DIV = 25_000_000,
    parameter int SCAN_DIV  = 50_000_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [17:0] board,
    input  logic [3:0]  cursor,
    input  logic        turn,
    input  logic [1:0]  winner,
    input  logic        end_sig,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX0,
    output logic [1:0]  disp_row
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    disp_state_t   state;
    disp_state_t   rstate;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    play_row;
    logic [1:0]    row;
    logic [1:0]    cell_row;
    logic          show_cells;
    logic          cursor_hidden;
    logic [1:0]    code [3];
    logic          blank [3];
    logic [6:0]    glyph [3];
    logic [6:0]    n5, n4, n3;

    // Frame sequencer: end_sig enters the scan loop; dropping it returns to PLAY.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= PLAY;
            scan_cnt <= '0;
        end else if (state == PLAY) begin
            scan_cnt <= '0;
            if (end_sig) state <= SCAN0;
        end else if (!end_sig) begin
            state    <= PLAY;
            scan_cnt <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            case (state)
                SCAN0:   state <= SCAN1;
                SCAN1:   state <= SCAN2;
                SCAN2:   state <= RESULT;
                default: state <= SCAN0;
            endcase
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

`ifdef BOARD_DISP_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [3:0]    cursor_q;

    // Blink timer runs only while PLAY is rendered; a cursor move restarts it visible.
    always_ff @(posedge clk) begin
        cursor_q <= cursor;
        if (!resetn || rstate != PLAY || cursor != cursor_q) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // The move itself forces visibility in the same cycle it is seen.
    assign cursor_hidden = blink_phase && (cursor == cursor_q);
`else
    assign cursor_hidden = 1'b0;
`endif

    // Row of the cursor during play; no cursor shows row 0.
    always_comb begin
        if (cursor < 4'd3)      play_row = 2'd0;
        else if (cursor < 4'd6) play_row = 2'd1;
        else if (cursor < 4'd9) play_row = 2'd2;
        else                    play_row = 2'd0;
    end

    // Select what is rendered; a dropped end_sig shows PLAY immediately, ahead
    // of the state register, so an abort is visible one clk after it happens.
    always_comb begin
        rstate     = end_sig ? state : PLAY;
        row        = 2'd0;
        show_cells = 1'b1;
        n5         = GLYPH_BLANK;
        n4         = GLYPH_BLANK;
        n3         = GLYPH_BLANK;
        case (rstate)
            PLAY: begin
                row = play_row;
                n5  = digit_glyph(play_row);
                n4  = turn ? GLYPH_2 : GLYPH_1;
            end
            SCAN0: begin
                row = 2'd0;
                n5  = GLYPH_0;
            end
            SCAN1: begin
                row = 2'd1;
                n5  = GLYPH_1;
            end
            SCAN2: begin
                row = 2'd2;
                n5  = GLYPH_2;
            end
            default: begin
                row        = 2'd3;
                show_cells = 1'b0;
                case (winner)
                    WIN_P1: begin
                        n5 = GLYPH_P;
                        n4 = GLYPH_1;
                    end
                    WIN_P2: begin
                        n5 = GLYPH_P;
                        n4 = GLYPH_2;
                    end
                    WIN_DRAW: begin
                        n5 = GLYPH_D;
                        n4 = GLYPH_R;
                    end
                    default: begin
                        n5 = GLYPH_EMPTY;
                        n4 = GLYPH_EMPTY;
                    end
                endcase
            end
        endcase
    end

    // Cell codes of the shown row and the per-cell cursor blank flag.
    always_comb begin
        cell_row = (row == 2'd3) ? 2'd0 : row;
        for (int unsigned j = 0; j < 3; j++) begin
            code[j]  = board[2*(3*cell_row + j) +: 2];
            blank[j] = cursor_hidden && (rstate == PLAY) && (cursor < 4'd9) &&
                       (int'(cursor) == int'(3*cell_row + j));
        end
    end

    cell_glyph u_glyph2 (.code(code[0]), .blank(blank[0]), .seg(glyph[0]));
    cell_glyph u_glyph1 (.code(code[1]), .blank(blank[1]), .seg(glyph[1]));
    cell_glyph u_glyph0 (.code(code[2]), .blank(blank[2]), .seg(glyph[2]));

    // Output register: every display output is one clk behind its inputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            HEX5     <= '1;
            HEX4     <= '1;
            HEX3     <= '1;
            HEX2     <= '1;
            HEX1     <= '1;
            HEX0     <= '1;
            disp_row <= '0;
        end else begin
            HEX5     <= n5;
            HEX4     <= n4;
            HEX3     <= n3;
            HEX2     <= show_cells ? glyph[0] : GLYPH_BLANK;
            HEX1     <= show_cells ? glyph[1] : GLYPH_BLANK;
            HEX0     <= show_cells ? glyph[2] : GLYPH_BLANK;
            disp_row <= row;
        end
    end

endmodule
